// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulator.
// Builds with or without MAC_ACC_SATURATE_EN; this package is the same in both builds.
package mac_pkg;

    localparam int unsigned ACC_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [0:0] {
        StAcc,
        StHold
    } mac_state_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// Beat input and frame-result output handshakes of the MAC accumulator.
// Master is the environment side; slave is the accumulator side.
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_sum;
    logic             in_carry;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_beats;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_carry, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_beats, out_ovf
    );

endinterface

// File: rtl/mac_acc_add.sv
// ACC_W-bit adder returning sum and carry-out.
// With MAC_ACC_SATURATE_EN defined the sum clamps to all-ones on carry-out.
module mac_acc_add #(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[ACC_W];

`ifdef MAC_ACC_SATURATE_EN
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator for {carry, sum} beats with a one-deep result hold stage.
// Accumulator overflow behaviour depends on MAC_ACC_SATURATE_EN (see mac_acc_add).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    mac_accumulator_if.slave  bus
);

    mac_state_e       r_state;
    mac_state_e       w_state_d;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_d;
    logic [ACC_W-1:0] w_base_acc;
    logic [ACC_W-1:0] w_beat;
    logic [ACC_W-1:0] w_add_sum;
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] w_beats_d;
    logic [CNT_W-1:0] w_base_beats;
    logic             r_ovf;
    logic             w_ovf_d;
    logic             w_base_ovf;
    logic             w_add_carry;
    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_handoff;

    assign w_out_valid = (r_state == StHold);
    assign w_in_ready  = !w_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_handoff   = w_out_valid && bus.out_ready;
    assign w_beat      = {{(ACC_W-7){1'b0}}, bus.in_carry, bus.in_sum};

    // A handoff clears the frame before any beat on the same edge is added.
    assign w_base_acc   = w_handoff ? '0 : r_acc;
    assign w_base_beats = w_handoff ? '0 : r_beats;
    assign w_base_ovf   = w_handoff ? 1'b0 : r_ovf;

    mac_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a     (w_base_acc),
        .i_b     (w_beat),
        .o_sum   (w_add_sum),
        .o_carry (w_add_carry)
    );

    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_beats_d = r_beats;
        w_ovf_d   = r_ovf;
        if (w_accept) begin
            w_acc_d   = w_add_sum;
            w_beats_d = (w_base_beats == {CNT_W{1'b1}}) ? w_base_beats
                                                         : w_base_beats + CNT_W'(1);
            w_ovf_d   = w_base_ovf | w_add_carry;
            w_state_d = bus.in_last ? StHold : StAcc;
        end else if (w_handoff) begin
            w_acc_d   = '0;
            w_beats_d = '0;
            w_ovf_d   = 1'b0;
            w_state_d = StAcc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StAcc;
            r_acc   <= '0;
            r_beats <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
            r_beats <= w_beats_d;
            r_ovf   <= w_ovf_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_acc   = r_acc;
    assign bus.out_beats = r_beats;
    assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator at ACC_W=8; expectations follow MAC_ACC_SATURATE_EN.
module tb_mac_accumulator;

    localparam int unsigned ACC_W = 8;
    localparam int unsigned CNT_W = 8;

`ifdef MAC_ACC_SATURATE_EN
    localparam int unsigned OVF_ACC = 255;
`else
    localparam int unsigned OVF_ACC = 8;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mac_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mac_accumulator #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [6:0] v, input logic last);
        bus.in_valid = 1'b1;
        bus.in_carry = v[6];
        bus.in_sum   = v[5:0];
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int acc, input int beats, input bit ovf);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_acc"},   32'(bus.out_acc),   32'(acc));
        check_eq({tag, "_beats"}, 32'(bus.out_beats), 32'(beats));
        check_eq({tag, "_ovf"},   32'(bus.out_ovf),   32'(ovf));
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_acc",       32'(bus.out_acc),   32'd0);
        check_eq("rst_beats",     32'(bus.out_beats), 32'd0);
        check_eq("rst_ovf",       32'(bus.out_ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 10, idle, 20, 127 last -> 157 / 3
        bus.out_ready = 1'b1;
        send_beat(7'd10, 1'b0);
        step();
        step();
        send_beat(7'd20, 1'b0);
        check_eq("f1_not_yet_valid", 32'(bus.out_valid), 32'd0);
        send_beat(7'd127, 1'b1);
        check_frame("f1", 157, 3, 1'b0);
        step();
        check_eq("f1_handoff_valid", 32'(bus.out_valid), 32'd0);

        // carry=1, sum=3F single beat -> 127 / 1
        send_beat(7'h7F, 1'b1);
        check_frame("f2", 127, 1, 1'b0);
        step();
        check_eq("f2_handoff_valid", 32'(bus.out_valid), 32'd0);

        // Stall in HOLD for 5 cycles with a pending beat of 5
        bus.out_ready = 1'b0;
        send_beat(7'd3, 1'b0);
        send_beat(7'd4, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_carry = 1'b0;
        bus.in_sum   = 6'd5;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check_frame("stall", 7, 2, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check_eq("release_valid", 32'(bus.out_valid), 32'd0);
        send_beat(7'd1, 1'b1);
        check_frame("f3", 6, 2, 1'b0);

        // Last beat arriving on a handoff edge -> straight back to HOLD
        send_beat(7'd9, 1'b1);
        check_frame("f4", 9, 1, 1'b0);
        step();
        check_eq("f4_handoff_valid", 32'(bus.out_valid), 32'd0);

        // Overflow at ACC_W=8: 127 + 127 + 10
        send_beat(7'd127, 1'b0);
        send_beat(7'd127, 1'b0);
        send_beat(7'd10, 1'b1);
        check_frame("ovf", int'(OVF_ACC), 3, 1'b1);
        step();
        send_beat(7'd2, 1'b1);
        check_frame("ovf_cleared", 2, 1, 1'b0);
        step();

        // Reset mid-frame discards the partial frame
        send_beat(7'd1, 1'b0);
        send_beat(7'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_eq("mid_rst_valid",    32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        send_beat(7'd7, 1'b1);
        check_frame("after_rst", 7, 1, 1'b0);
        step();

        // Beat counter saturation: 300 zero beats
        for (int i = 0; i < 299; i++) begin
            send_beat(7'd0, 1'b0);
        end
        send_beat(7'd0, 1'b1);
        check_frame("cnt_sat", 0, 255, 1'b0);
        step();
        check_eq("cnt_sat_handoff", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 16: accumulator width in bits, legal range 8..32.
REQ-002 SHALL have parameter CNT_W, default 8: beat-counter width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream adder result valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts the current beat.
REQ-007 SHALL have port in_sum, input, 6: Sum from the upstream 6-bit three-operand adder.
REQ-008 SHALL have port in_carry, input, 1: Carry from the upstream adder; weight 2^6.
REQ-009 SHALL have port in_last, input, 1: marks the final beat of a frame.
REQ-010 SHALL have port out_valid, output, 1: frame result available.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_acc, output, ACC_W: accumulated frame total.
REQ-013 SHALL have port out_beats, output, CNT_W: number of beats in the frame.
REQ-014 SHALL have port out_ovf, output, 1: the frame overflowed ACC_W.

Function
REQ-015 SHALL form each beat value as {in_carry, in_sum}, zero-extended to ACC_W (range 0..127).
REQ-016 SHALL accept a beat only when in_valid=1 and in_ready=1 at the same rising edge.
REQ-017 SHALL implement the FSM ACC -> HOLD -> ACC: ACC accumulates beats; an accepted beat with in_last=1 moves to HOLD.
REQ-018 SHALL, in HOLD, hold out_valid=1 and keep out_acc, out_beats and out_ovf stable until out_ready=1.
REQ-019 SHALL drive in_ready = !out_valid || out_ready.
REQ-020 SHALL present out_valid=1 on the cycle after the edge that accepts the last beat (latency 1).
REQ-021 SHALL, on a result handoff, clear the running accumulator, beat count and overflow flag.
REQ-022 SHALL, when a handoff and a beat acceptance occur on the same edge, make that beat the first beat of the new frame; no beat is lost or duplicated.
REQ-023 SHALL, for a beat with in_last=1 that arrives during a handoff, return directly to HOLD with a one-beat frame.
REQ-024 SHALL leave all state unchanged on idle cycles (in_valid=0).
REQ-025 SHALL saturate the beat count at 2^CNT_W-1; it never wraps.
REQ-026 SHALL set out_ovf when any addition in the frame carries out of ACC_W; the flag is sticky until handoff.

Reset
REQ-027 SHALL, while rst=1, asynchronously force the FSM to ACC, the accumulator to 0, out_beats=0, out_ovf=0 and out_valid=0.
REQ-028 SHALL output in_ready=1 while rst=1 and after reset release.
REQ-029 SHALL discard a partial frame if reset is asserted mid-frame; no result is emitted for it.

Configuration
REQ-030 SHALL support macro MAC_ACC_SATURATE_EN, compiled in or out.
REQ-031 SHALL, with MAC_ACC_SATURATE_EN defined, clamp the accumulator to 2^ACC_W-1 on overflow and hold it there for the rest of the frame.
REQ-032 SHALL, without MAC_ACC_SATURATE_EN, wrap the accumulator modulo 2^ACC_W; out_ovf behaves identically in both builds.

Structure
REQ-033 SHALL place the FSM state enum (ACC, HOLD) and default widths (ACC_W=16, CNT_W=8) in the shared package mac_pkg.
REQ-034 SHALL contain one sub-module, mac_acc_add: an ACC_W adder returning sum and carry-out, with saturation under the macro; the FSM and handshake stay in mac_accumulator.

Verification
REQ-035 SHALL verify: beats 10, 20, 127 (last=1), out_ready=1 -> out_valid one cycle later, out_acc=157, out_beats=3, out_ovf=0.
REQ-036 SHALL verify: {carry=1, sum=6'h3F} single beat with last=1 -> out_acc=127, out_beats=1.
REQ-037 SHALL verify: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 on the same edge, value 5 -> next frame starts at 5.
REQ-038 SHALL verify: ACC_W=8, beats 127, 127, 10 (last) -> wrap build: out_acc=8, out_ovf=1; MAC_ACC_SATURATE_EN build: out_acc=255, out_ovf=1.
REQ-039 SHALL verify: rst pulse after 2 beats, then beat 7 with last=1 -> out_acc=7, out_beats=1.
REQ-040 SHALL verify: 300 beats of value 0, last on beat 300 -> out_beats=255, out_acc=0.
